// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754 binary32 multiplier: 24-cycle shift-add, normalize, round-to-nearest-even.
// Denormal operands are flushed to zero, and results below the normal range flush to signed zero.
module fp_mul_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  typedef enum logic [2:0] {StIdle, StMult, StNorm, StRound, StDone} state_e;

  state_e             state_q;
  logic               sign_q;
  logic signed [9:0]  exp_q;
  logic [23:0]        ma_q;
  logic [23:0]        mb_q;
  logic [47:0]        prod_q;
  logic [4:0]         cnt_q;
  logic [22:0]        mant_q;
  logic               guard_q;
  logic               sticky_q;

  // Operand decode, evaluated at accept.
  logic [7:0]         ea;
  logic [7:0]         eb;
  logic               a_zero, a_inf, a_nan;
  logic               b_zero, b_inf, b_nan;
  logic               op_sign;
  logic               is_special;
  logic [31:0]        special_res;
  logic [3:0]         special_flags;
  logic signed [9:0]  exp_sum;

  assign ea      = a[30:23];
  assign eb      = b[30:23];
  assign a_zero  = (ea == 8'd0);
  assign b_zero  = (eb == 8'd0);
  assign a_inf   = (ea == 8'hFF) && (a[22:0] == 23'd0);
  assign b_inf   = (eb == 8'hFF) && (b[22:0] == 23'd0);
  assign a_nan   = (ea == 8'hFF) && (a[22:0] != 23'd0);
  assign b_nan   = (eb == 8'hFF) && (b[22:0] != 23'd0);
  assign op_sign = a[31] ^ b[31];
  assign exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;

  always_comb begin
    special_res   = '0;
    special_flags = '0;
    is_special    = 1'b1;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      special_res   = 32'h7FC0_0000;
      special_flags = 4'b1000;
    end else if (a_inf || b_inf) begin
      special_res = {op_sign, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      special_res = {op_sign, 31'd0};
    end else begin
      is_special = 1'b0;
    end
  end

  // Normalization: the 24x24 product of [1,2) mantissas lies in [1,4).
  logic [22:0]        norm_mant;
  logic               norm_guard;
  logic               norm_sticky;
  logic signed [9:0]  norm_exp;

  always_comb begin
    if (prod_q[47]) begin
      norm_mant   = prod_q[46:24];
      norm_guard  = prod_q[23];
      norm_sticky = |prod_q[22:0];
      norm_exp    = exp_q + 10'sd1;
    end else begin
      norm_mant   = prod_q[45:23];
      norm_guard  = prod_q[22];
      norm_sticky = |prod_q[21:0];
      norm_exp    = exp_q;
    end
  end

  // Round to nearest, ties to even; a carry out of the mantissa bumps the exponent.
  logic               round_up;
  logic [23:0]        mant_inc;
  logic signed [9:0]  exp_rnd;

  assign round_up = guard_q && (sticky_q || mant_q[0]);
  assign mant_inc = {1'b0, mant_q} + {23'd0, round_up};
  assign exp_rnd  = mant_inc[23] ? (exp_q + 10'sd1) : exp_q;

  assign in_ready = (state_q == StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      ma_q      <= '0;
      mb_q      <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
      mant_q    <= '0;
      guard_q   <= 1'b0;
      sticky_q  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            sign_q <= op_sign;
            if (is_special) begin
              result    <= special_res;
              flags     <= special_flags;
              out_valid <= 1'b1;
              state_q   <= StDone;
            end else begin
              exp_q   <= exp_sum;
              ma_q    <= {1'b1, a[22:0]};
              mb_q    <= {1'b1, b[22:0]};
              prod_q  <= '0;
              cnt_q   <= '0;
              state_q <= StMult;
            end
          end
        end
        StMult: begin
          if (mb_q[cnt_q]) begin
            prod_q <= prod_q + ({24'd0, ma_q} << cnt_q);
          end
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd23) begin
            state_q <= StNorm;
          end
        end
        StNorm: begin
          mant_q   <= norm_mant;
          guard_q  <= norm_guard;
          sticky_q <= norm_sticky;
          exp_q    <= norm_exp;
          state_q  <= StRound;
        end
        StRound: begin
          if (exp_rnd >= 10'sd255) begin
            result <= {sign_q, 8'hFF, 23'd0};
            flags  <= 4'b0101;
          end else if (exp_rnd <= 10'sd0) begin
            result <= {sign_q, 31'd0};
            flags  <= 4'b0011;
          end else begin
            result <= {sign_q, exp_rnd[7:0], mant_inc[22:0]};
            flags  <= {3'b000, guard_q | sticky_q};
          end
          out_valid <= 1'b1;
          state_q   <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Bench for fp_mul_seq: directed corner cases plus random operands against an
// integer-arithmetic reference of binary32 multiplication (flush-to-zero, RNE).
module tb_fp_mul_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_pass   = 0;

  fp_mul_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: exact integer product, then round by comparing the discarded part with one half.
  task automatic model(input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] r, output logic [3:0] f, output bit special);
    int unsigned ex, ey;
    bit s, xz, yz, xi, yi, xn, yn;
    longint unsigned p, q, rem, half;
    int e, sh;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    s  = x[31] ^ y[31];
    xz = (ex == 0);
    yz = (ey == 0);
    xi = (ex == 255) && (x[22:0] == 0);
    yi = (ey == 255) && (y[22:0] == 0);
    xn = (ex == 255) && (x[22:0] != 0);
    yn = (ey == 255) && (y[22:0] != 0);
    special = 1'b1;
    f = 4'b0000;
    if (xn || yn || (xi && yz) || (yi && xz)) begin
      r = 32'h7FC0_0000;
      f = 4'b1000;
    end else if (xi || yi) begin
      r = {s, 8'hFF, 23'd0};
    end else if (xz || yz) begin
      r = {s, 31'd0};
    end else begin
      special = 1'b0;
      p = longint'({1'b1, x[22:0]}) * longint'({1'b1, y[22:0]});
      e = int'(ex) + int'(ey) - 127;
      if (p >= (64'd1 << 47)) begin
        sh = 24;
        e++;
      end else begin
        sh = 23;
      end
      q    = p >> sh;
      rem  = p & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (64'd1 << 24)) begin
        q = 64'd1 << 23;
        e++;
      end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'd0};
        f = 4'b0101;
      end else if (e <= 0) begin
        r = {s, 31'd0};
        f = 4'b0011;
      end else begin
        r = {s, e[7:0], q[22:0]};
        f = {3'b000, rem != 0};
      end
    end
  endtask

  task automatic run_op(input logic [31:0] xa, input logic [31:0] xb, input int hold,
                        input string tag);
    logic [31:0] er;
    logic [3:0]  ef;
    bit          sp;
    int          n;
    model(xa, xb, er, ef, sp);
    @(negedge clk);
    check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
    a         = xa;
    b         = xb;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    n        = 0;
    while (!out_valid && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    // Specials show out_valid right after the accept edge; normal ops after 26 further edges.
    check({tag, " latency"}, 32'(n), sp ? 32'd0 : 32'd26);
    check({tag, " result"}, result, er);
    check({tag, " flags"}, 32'(flags), 32'(ef));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a        = $urandom;
      b        = $urandom;
      @(posedge clk);
      #1;
      check({tag, " hold result"}, result, er);
      check({tag, " hold flags"}, 32'(flags), 32'(ef));
      check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
      check({tag, " hold out_valid"}, 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, " handoff out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " handoff in_ready"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    int          k;
    v = $urandom;
    k = $urandom_range(0, 15);
    if (k == 0) v[30:23] = 8'd0;
    else if (k == 1) begin
      v[30:23] = 8'hFF;
      if ($urandom_range(0, 1) == 0) v[22:0] = '0;
    end else if (k == 2) v[30:23] = 8'($urandom_range(1, 254));
    else if (k == 3) v[22:0] = '0;
    else v[30:23] = 8'($urandom_range(60, 194));
    if (k == 3) v[30:23] = 8'($urandom_range(100, 154));
    return v;
  endfunction

  initial begin
    int cnt;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) @(negedge clk);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", result, 32'd0);
    check("reset flags", 32'(flags), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd1);

    run_op(32'h3F80_0000, 32'h3F80_0000, 0, "one_x_one");
    run_op(32'h3FC0_0000, 32'h3FC0_0000, 0, "1p5_sq");
    run_op(32'h3F80_0001, 32'h3F80_0001, 0, "tie_low");
    run_op(32'h7F00_0000, 32'h7F00_0000, 0, "overflow");
    run_op(32'h7F80_0000, 32'h0000_0000, 0, "inf_x_zero");
    run_op(32'h0080_0000, 32'h0080_0000, 0, "underflow");
    run_op(32'h3F7F_FFFF, 32'h3F80_0001, 0, "carry_out");
    run_op(32'hFF80_0000, 32'h4000_0000, 0, "neg_inf");
    run_op(32'h0000_1234, 32'hC000_0000, 0, "denorm_ftz");
    run_op(32'h7FC1_2345, 32'h3F80_0000, 0, "nan_in");
    run_op(32'h4049_0FDB, 32'hC02D_F854, 10, "backpressure");

    // Abort in the middle of MULT: no result may appear afterwards.
    @(negedge clk);
    a        = 32'h3FC0_0000;
    b        = 32'h4049_0FDB;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort result", result, 32'd0);
    check("abort flags", 32'(flags), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort in_ready", 32'(in_ready), 32'd1);
    cnt = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (out_valid) cnt++;
    end
    check("abort no result", 32'(cnt), 32'd0);
    run_op(32'h3FC0_0000, 32'h3FC0_0000, 0, "after_abort");

    for (int i = 0; i < 150; i++) begin
      run_op(rand_fp(), rand_fp(), $urandom_range(0, 2), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
